// File: rtl/tx_len_requester.sv
// tx_len_requester: sends a 32-bit length as four LSB-first bytes on an 8-bit stream,
// then counts the bytes of the 32-bit tkeep/tlast response and reports length, keep
// and timeout errors with a one-cycle done pulse.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both
// high. The request side (o_tvalid/o_tready) holds o_tdata stable until accepted. The
// response side raises i_tready only in RECV, so beats offered at any other time are
// held off and never counted.
module tx_len_requester #(
  parameter int TIMEOUT_W = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] req_len,
  output logic        busy,
  output logic        done,
  output logic        err_len,
  output logic        err_keep,
  output logic        err_timeout,
  output logic [31:0] rx_bytes,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic [7:0]  o_tdata,
  output logic        i_tready,
  input  logic        i_tvalid,
  input  logic [31:0] i_tdata,
  input  logic [3:0]  i_tkeep,
  input  logic        i_tlast,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_RECV = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Timeout fires when the idle counter would step onto all-ones.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t               r_state;
  state_t               w_state_nxt;
  logic [31:0]          r_len;
  logic [1:0]           r_idx;
  logic [31:0]          r_bytes;
  logic                 r_err_keep;
  logic                 r_err_tmo;
  logic                 r_err_len;
  logic [TIMEOUT_W-1:0] r_tmo;

  logic                 w_send_hs;
  logic                 w_beat;
  logic                 w_keep_ok;
  logic [2:0]           w_pop;
  logic [31:0]          w_bytes_nxt;
  logic                 w_tmo_hit;
  logic                 w_unused;

  // Response payload only matters for its byte enables.
  assign w_unused = ^i_tdata;

  assign w_send_hs   = (r_state == S_SEND) && o_tready;
  assign w_beat      = (r_state == S_RECV) && i_tvalid;
  assign w_pop       = {2'b00, i_tkeep[0]} + {2'b00, i_tkeep[1]} +
                       {2'b00, i_tkeep[2]} + {2'b00, i_tkeep[3]};
  assign w_bytes_nxt = r_bytes + {29'd0, w_pop};
  assign w_tmo_hit   = (r_state == S_RECV) && !i_tvalid && (r_tmo == TMO_LAST);

  // Only low-aligned contiguous byte enables are legal; all-zero is not.
  always_comb begin
    w_keep_ok = 1'b0;
    case (i_tkeep)
      4'b0001, 4'b0011, 4'b0111, 4'b1111: w_keep_ok = 1'b1;
      default:                            w_keep_ok = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state and Moore outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    o_tvalid    = 1'b0;
    o_tdata     = 8'd0;
    i_tready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_SEND;
      end
      S_SEND: begin
        busy     = 1'b1;
        o_tvalid = 1'b1;
        o_tdata  = r_len[{r_idx, 3'b000} +: 8];
        if (w_send_hs && (r_idx == 2'd3))
          w_state_nxt = (r_len == 32'd0) ? S_DONE : S_RECV;
      end
      S_RECV: begin
        busy     = 1'b1;
        i_tready = 1'b1;
        if ((w_beat && i_tlast) || w_tmo_hit) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Transaction datapath: captured length, byte index, byte count, idle timer, error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len      <= 32'd0;
      r_idx      <= 2'd0;
      r_bytes    <= 32'd0;
      r_err_keep <= 1'b0;
      r_err_tmo  <= 1'b0;
      r_err_len  <= 1'b0;
      r_tmo      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len      <= req_len;
            r_idx      <= 2'd0;
            r_bytes    <= 32'd0;
            r_err_keep <= 1'b0;
            r_err_tmo  <= 1'b0;
            r_err_len  <= 1'b0;
          end
        end
        S_SEND: begin
          if (w_send_hs) begin
            r_idx <= r_idx + 2'd1;
            r_tmo <= '0;
            // A zero-length request finishes here with nothing to receive.
            if (r_idx == 2'd3) r_err_len <= (r_bytes != r_len);
          end
        end
        S_RECV: begin
          if (w_beat) begin
            r_bytes <= w_bytes_nxt;
            r_tmo   <= '0;
            if (!w_keep_ok) r_err_keep <= 1'b1;
            if (i_tlast)    r_err_len  <= (w_bytes_nxt != r_len);
          end else begin
            r_tmo <= r_tmo + 1'b1;
            if (w_tmo_hit) begin
              r_err_tmo <= 1'b1;
              r_err_len <= (r_bytes != r_len);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign err_len     = r_err_len;
  assign err_keep    = r_err_keep;
  assign err_timeout = r_err_tmo;
  assign rx_bytes    = r_bytes;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tx_len_requester.sv
// Bench for tx_len_requester: directed scenarios followed by randomized transactions,
// all checked against a byte-count / error model built from the protocol rules.
module tb_tx_len_requester;

  localparam int TW = 4;
  localparam int TMO_IDLE = (1 << TW) - 1;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start;
  logic [31:0] req_len;
  logic        busy, done, err_len, err_keep, err_timeout;
  logic [31:0] rx_bytes;
  logic        o_tvalid, o_tready;
  logic [7:0]  o_tdata;
  logic        i_tready, i_tvalid;
  logic [31:0] i_tdata;
  logic [3:0]  i_tkeep;
  logic        i_tlast;
  logic [1:0]  dbg_state;

  tx_len_requester #(.TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst), .start(start), .req_len(req_len),
    .busy(busy), .done(done), .err_len(err_len), .err_keep(err_keep),
    .err_timeout(err_timeout), .rx_bytes(rx_bytes),
    .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tdata(o_tdata),
    .i_tready(i_tready), .i_tvalid(i_tvalid), .i_tdata(i_tdata),
    .i_tkeep(i_tkeep), .i_tlast(i_tlast), .o_dbg_state(dbg_state)
  );

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [3:0] keep_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: one full transaction with the response beats taken from keep_q.
  // tr_mode: 0 ready always, 1 ready toggling, 2 ready random.
  task automatic run_txn(input logic [31:0] len, input int tr_mode, input int max_gap,
                         input bit omit_last, input bit poke_start, input int abort_after);
    logic [31:0] exp_rx;
    bit          exp_kerr;
    bit          exp_tmo;
    bit          stall;
    logic [7:0]  prev_data;
    int          bi, gap, idle, recv_cycles, last_acc, cyc;
    bit          seen_done, aborted;
    exp_rx = 0; exp_kerr = 0; stall = 0; prev_data = 0;
    bi = 0; gap = 0; idle = 0; recv_cycles = 0; last_acc = -10;
    seen_done = 0; aborted = 0;
    // Reference model
    if (len != 0) begin
      foreach (keep_q[i]) begin
        exp_rx += $countones(keep_q[i]);
        if (!(keep_q[i] inside {4'b0001, 4'b0011, 4'b0111, 4'b1111})) exp_kerr = 1;
      end
    end
    exp_tmo = (len != 0) && omit_last;
    exp_q.delete();
    for (int b = 0; b < 4; b++) exp_q.push_back(len[8*b +: 8]);

    @(negedge clk);
    start = 1'b1; req_len = len;
    @(negedge clk);
    start = 1'b0; req_len = $urandom;
    chk("start_latency_tvalid", o_tvalid, 1'b1);
    chk("busy_in_send", busy, 1'b1);

    for (cyc = 0; cyc < 400; cyc++) begin
      if (done) begin seen_done = 1; break; end
      if (abort_after >= 0 && bi == abort_after && i_tready) begin
        rst = 1'b1;
        #1;
        chk("abort_rx_bytes", rx_bytes, 32'd0);
        chk("abort_ctrl", {busy, done, err_len, err_keep, err_timeout, o_tvalid, i_tready, o_tdata}, 32'd0);
        aborted = 1;
        break;
      end
      start = poke_start && (cyc == 1);
      if (start) req_len = $urandom;
      // request side
      if (o_tvalid) begin
        if (stall) chk("tdata_stable", o_tdata, prev_data);
        case (tr_mode)
          0:       o_tready = 1'b1;
          1:       o_tready = cyc[0];
          default: o_tready = 1'($urandom_range(0, 1));
        endcase
        if (o_tready) begin
          if (exp_q.size() == 0) chk("extra_tx_byte", 1, 0);
          else chk("tx_byte", o_tdata, exp_q.pop_front());
          stall = 0;
        end else begin
          stall = 1; prev_data = o_tdata;
        end
      end else begin
        o_tready = 1'($urandom_range(0, 1));
      end
      // response side
      if (bi < keep_q.size() && gap == 0) begin
        i_tvalid = 1'b1;
        i_tkeep  = keep_q[bi];
        i_tlast  = !omit_last && (bi == keep_q.size() - 1);
        i_tdata  = $urandom;
      end else begin
        i_tvalid = 1'b0;
        i_tkeep  = 4'($urandom);
        i_tlast  = 1'($urandom);
        if (gap > 0) gap--;
      end
      if (i_tready) begin
        recv_cycles++;
        if (i_tvalid) begin
          bi++; last_acc = cyc; idle = 0; gap = $urandom_range(0, max_gap);
        end else begin
          idle++;
        end
      end
      @(negedge clk);
    end
    start = 1'b0; i_tvalid = 1'b0; i_tlast = 1'b0; o_tready = 1'b0;

    if (aborted) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("abort_no_done", done, 1'b0);
      end
      rst = 1'b0;
      return;
    end
    if (!seen_done) begin
      chk("done_within_budget", 0, 1);
      return;
    end
    chk("rx_bytes", rx_bytes, exp_rx);
    chk("err_len", err_len, exp_rx != len);
    chk("err_keep", err_keep, exp_kerr);
    chk("err_timeout", err_timeout, exp_tmo);
    chk("idle_in_done", {busy, o_tvalid, i_tready}, 3'b000);
    chk("all_bytes_sent", exp_q.size(), 0);
    if (len == 0) chk("no_tready_len0", recv_cycles, 0);
    else if (!omit_last) chk("done_latency", cyc - last_acc, 1);
    if (exp_tmo) chk("timeout_idle_cycles", idle, TMO_IDLE);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    chk("rx_bytes_hold", rx_bytes, exp_rx);
    chk("err_len_hold", err_len, exp_rx != len);
  endtask

  logic [3:0]  legal[4] = '{4'h1, 4'h3, 4'h7, 4'hF};
  logic [31:0] rlen;
  logic [3:0]  k;
  int          sum, nb;

  initial begin
    rst = 1'b1; start = 1'b0; req_len = 32'd0; o_tready = 1'b0;
    i_tvalid = 1'b0; i_tdata = 32'd0; i_tkeep = 4'd0; i_tlast = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rx_bytes", rx_bytes, 32'd0);
    chk("reset_ctrl", {busy, done, err_len, err_keep, err_timeout, o_tvalid, i_tready, o_tdata}, 32'd0);
    rst = 1'b0;

    // basic 8-byte request
    keep_q = '{4'hF, 4'hF};
    run_txn(32'd8, 0, 0, 0, 0, -1);
    // toggling o_tready, partial last beat
    keep_q = '{4'hF, 4'h3};
    run_txn(32'd6, 1, 0, 0, 0, -1);
    // overrun, then illegal keep on the last beat
    keep_q = '{4'hF, 4'hF};
    run_txn(32'd5, 0, 0, 0, 0, -1);
    keep_q = '{4'hF, 4'h5};
    run_txn(32'd5, 0, 0, 0, 0, -1);
    // no response at all
    keep_q.delete();
    run_txn(32'd4, 0, 0, 1, 0, -1);
    // zero length with a beat offered and a start poked while busy
    keep_q = '{4'hF};
    run_txn(32'd0, 2, 0, 0, 1, -1);
    // timeout after some beats, all-zero keep
    keep_q = '{4'h1, 4'h0};
    run_txn(32'd2, 2, 2, 1, 0, -1);
    // reset during RECV after one beat, then a normal transaction
    keep_q = '{4'hF, 4'hF, 4'hF};
    run_txn(32'd12, 0, 0, 0, 0, 1);
    keep_q = '{4'h7, 4'h1};
    run_txn(32'd4, 0, 1, 0, 0, -1);

    // randomized transactions
    for (int r = 0; r < 30; r++) begin
      rlen = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(1, 24));
      keep_q.delete(); sum = 0; nb = 0;
      while (sum < rlen && nb < 12) begin
        k = legal[$urandom_range(0, 3)];
        if ($urandom_range(0, 5) == 0) k = 4'($urandom_range(0, 15));
        keep_q.push_back(k);
        sum += $countones(k); nb++;
      end
      run_txn(rlen, $urandom_range(0, 2), 3, ($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 1)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
